// File: rtl/bitslice_ctrl_if.sv
// Memory handshake port between the bit-slice controller (master) and memory (slave).
// mem_req stays high until mem_resp; mem_resp may rise in the same cycle as mem_req, and mem_rdata is valid only while mem_resp=1.
interface bitslice_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_wmask, input mem_resp, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_wmask, output mem_resp, mem_rdata);
endinterface

// File: rtl/bitslice_ctrl.sv
// Multicycle RV32I control FSM for the 32-slice bit-sliced datapath.
// Fetches into an internal IR, decodes it and drives all per-slice controls from state and IR.
module bitslice_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  bitslice_ctrl_if.master        mem,
  input  logic [1:0]             alu_addr_lo,
  input  logic                   cmp_out,
  output logic                   addr_sel,
  output logic [31:0]            rs1_sel,
  output logic [31:0]            rs2_sel,
  output logic [31:0]            rd_sel,
  output logic                   alu_mux_1_sel,
  output logic                   alu_mux_2_sel,
  output logic                   alu_inv_rs2,
  output logic                   alu_cin,
  output logic [1:0]             alu_op,
  output logic                   shift_dir,
  output logic                   shift_arith,
  output logic                   cmp_mux_sel,
  output logic                   cmp_unsigned,
  output logic                   pc_mux_sel,
  output logic                   pc_en,
  output logic [2:0]             mem_mux_sel,
  output logic [2:0]             rd_mux_sel,
  output logic                   lb,
  output logic                   lh,
  output logic                   lw,
  output logic                   lbu,
  output logic                   lhu,
  output logic [31:0]            imm,
  output logic                   trap,
  output logic [31:0]            pc_rst_vec,
  output logic [2:0]             state_dbg
);
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [2:0]  state, state_nxt;
  logic [31:0] ir;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;

  assign opcode     = ir[6:0];
  assign f3         = ir[14:12];
  assign f7         = ir[31:25];
  assign rd         = ir[11:7];
  assign pc_rst_vec = RESET_PC;
  assign state_dbg  = state;

  logic is_load, is_store, is_branch, is_jump;
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

  logic        legal, d_writes, d_mux1, d_mux2, d_inv, d_sdir, d_sarith, d_cmp_imm, d_cmp_uns;
  logic [1:0]  d_op;
  logic [2:0]  d_rd_mux;
  logic [31:0] imm_dec;
  logic [3:0]  wmask_dec;

  always_comb begin
    legal = 1'b0; d_writes = 1'b0; d_mux1 = 1'b0; d_mux2 = 1'b0; d_inv = 1'b0;
    d_sdir = 1'b0; d_sarith = 1'b0; d_cmp_imm = 1'b0; d_cmp_uns = 1'b0;
    d_op = 2'b00; d_rd_mux = 3'd0;
    case (opcode)
      OPC_LUI:    begin legal = 1'b1; d_writes = 1'b1; d_rd_mux = 3'd5; end
      OPC_AUIPC:  begin legal = 1'b1; d_writes = 1'b1; d_mux1 = 1'b1; d_mux2 = 1'b1; end
      OPC_JAL:    begin legal = 1'b1; d_writes = 1'b1; d_mux1 = 1'b1; d_mux2 = 1'b1; d_rd_mux = 3'd4; end
      OPC_JALR:   begin legal = (f3 == 3'b000); d_writes = 1'b1; d_mux2 = 1'b1; d_rd_mux = 3'd4; end
      // The ALU forms the branch target; the taken test comes from the separate compare chain.
      OPC_BRANCH: begin legal = (f3 != 3'b010) && (f3 != 3'b011); d_mux1 = 1'b1; d_mux2 = 1'b1; d_cmp_uns = f3[1]; end
      OPC_LOAD:   begin legal = (f3 != 3'b011) && (f3 < 3'b110); d_writes = 1'b1; d_mux2 = 1'b1; d_rd_mux = 3'd3; end
      OPC_STORE:  begin legal = (f3 < 3'b011); d_mux2 = 1'b1; end
      OPC_OPIMM, OPC_OP: begin
        d_writes  = 1'b1;
        d_mux2    = (opcode == OPC_OPIMM);
        d_cmp_imm = (opcode == OPC_OPIMM);
        if (opcode == OPC_OPIMM)
          legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                  (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        else
          legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        case (f3)
          3'b000: d_inv = (opcode == OPC_OP) && f7[5];
          3'b001: d_rd_mux = 3'd1;
          3'b010: begin d_rd_mux = 3'd2; d_inv = 1'b1; end
          3'b011: begin d_rd_mux = 3'd2; d_inv = 1'b1; d_cmp_uns = 1'b1; end
          3'b100: d_op = 2'b01;
          3'b101: begin d_rd_mux = 3'd1; d_sdir = 1'b1; d_sarith = f7[5]; end
          3'b110: d_op = 2'b10;
          default: d_op = 2'b11;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OPC_STORE:            imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:           imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:   imm_dec = {ir[31:12], 12'b0};
      OPC_JAL:              imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:              imm_dec = {{20{ir[31]}}, ir[31:20]};
    endcase
    case (f3[1:0])
      2'b00:   wmask_dec = 4'b0001 << alu_addr_lo;
      2'b01:   wmask_dec = 4'b0011 << {alu_addr_lo[1], 1'b0};
      default: wmask_dec = 4'hF;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (mem.mem_resp) state_nxt = DECODE;
      DECODE:  state_nxt = legal ? EXEC : TRAP;
      EXEC:    state_nxt = (is_load || is_store) ? MEM : WB;
      MEM:     if (mem.mem_resp) state_nxt = WB;
      WB:      state_nxt = FETCH;
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      ir    <= 32'h0000_0013;
    end else begin
      state <= state_nxt;
      if (state == FETCH && mem.mem_resp) ir <= mem.mem_rdata;
    end
  end

  always_comb begin
    mem.mem_req = 1'b0; mem.mem_we = 1'b0; mem.mem_wmask = 4'h0;
    addr_sel = 1'b0; rs1_sel = 32'h0; rs2_sel = 32'h0; rd_sel = 32'h0; imm = 32'h0;
    alu_mux_1_sel = 1'b0; alu_mux_2_sel = 1'b0; alu_inv_rs2 = 1'b0; alu_cin = 1'b0; alu_op = 2'b00;
    shift_dir = 1'b0; shift_arith = 1'b0; cmp_mux_sel = 1'b0; cmp_unsigned = 1'b0;
    pc_mux_sel = 1'b0; pc_en = 1'b0; mem_mux_sel = 3'd0; rd_mux_sel = 3'd0;
    lb = 1'b0; lh = 1'b0; lw = 1'b0; lbu = 1'b0; lhu = 1'b0; trap = 1'b0;
    // The reset cycle only loads the reset PC into the slices.
    if (rst) pc_en = 1'b1;
    else begin
      if (state inside {DECODE, EXEC, MEM, WB}) begin
        rs1_sel = 32'd1 << ir[19:15];
        rs2_sel = 32'd1 << ir[24:20];
        imm     = imm_dec;
      end
      if (state inside {EXEC, MEM, WB}) begin
        alu_mux_1_sel = d_mux1;   alu_mux_2_sel = d_mux2;
        alu_inv_rs2   = d_inv;    alu_cin       = d_inv;
        alu_op        = d_op;     shift_dir     = d_sdir;   shift_arith = d_sarith;
        cmp_mux_sel   = d_cmp_imm; cmp_unsigned = d_cmp_uns; rd_mux_sel = d_rd_mux;
        if (is_load) begin
          mem_mux_sel = f3;
          lb  = (f3 == 3'b000); lh  = (f3 == 3'b001); lw = (f3 == 3'b010);
          lbu = (f3 == 3'b100); lhu = (f3 == 3'b101);
        end
      end
      case (state)
        FETCH: mem.mem_req = 1'b1;
        MEM: begin
          mem.mem_req = 1'b1;
          addr_sel    = 1'b1;
          mem.mem_we  = is_store;
          if (is_store) mem.mem_wmask = wmask_dec;
        end
        WB: begin
          pc_en      = 1'b1;
          pc_mux_sel = is_jump || (is_branch && (cmp_out ^ f3[0]));
          if (d_writes && rd != 5'd0) rd_sel = 32'd1 << rd;
        end
        TRAP:    trap = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/bitslice_ctrl.md
Name: bitslice_ctrl

Overview:
- Multicycle control FSM for the 32-slice bit-sliced RV32I datapath.
- Fetches the instruction over a single memory handshake port and holds it in an internal instruction register (IR).
- Decodes the IR and drives every per-slice control input (register selects, mux selects, ALU and shift controls, load controls, immediate bits) state by state.
- Sits between the top level and the bitslice array; it is the only sequential controller in the core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value the datapath loads on reset; sets pc_rst_vec.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- mem_req  out  1  memory request. Held until mem_resp.
- mem_we  out  1  write request (stores only).
- mem_wmask  out  4  byte enables for stores.
- mem_resp  in  1  request complete. May assert in the same cycle as mem_req.
- mem_rdata  in  32  instruction or load data. Valid when mem_resp=1.
- addr_sel  out  1  memory address source: 0=pc, 1=alu_out.
- rs1_sel, rs2_sel  out  32  one-hot decode of IR[19:15] and IR[24:20].
- rd_sel  out  32  one-hot write strobe. Asserted only in WB.
- alu_mux_1_sel  out  1  0=rs1, 1=pc.
- alu_mux_2_sel  out  1  0=rs2, 1=imm.
- alu_inv_rs2  out  1  invert rs2. alu_cin carries the matching +1.
- alu_cin  out  1  carry into slice 0.
- alu_op  out  2  00 add, 01 xor, 10 or, 11 and.
- shift_dir  out  1  0 left, 1 right.
- shift_arith  out  1  sign-fill right shift.
- cmp_mux_sel  out  1  0=rs2, 1=imm.
- cmp_unsigned  out  1  unsigned compare.
- pc_mux_sel  out  1  0=pc+4, 1=alu_out.
- pc_en  out  1  PC register load enable.
- mem_mux_sel  out  3  funct3 of the current load.
- rd_mux_sel  out  3  0 alu, 1 shift, 2 slt, 3 mem, 4 pc+4, 5 imm.
- lb, lh, lw, lbu, lhu  out  1 each  load-type one-hot.
- imm  out  32  decoded immediate, one bit per slice.
- cmp_out  in  1  compare result from the MSB slice.
- trap  out  1  illegal instruction; sticky until reset.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. The state register and IR are updated on posedge clk.
- Reset:
  - state=FETCH, IR=32'h0000_0013 (NOP), trap=0.
  - All outputs 0 during the reset cycle, except pc_en=1 with pc_mux_sel=0; the slices load pc_reset_value.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - On mem_resp: IR<=mem_rdata, go to DECODE. Otherwise hold with mem_req=1.
- DECODE:
  - One cycle. rs1_sel/rs2_sel driven from IR; imm driven.
  - Opcodes outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}, or any illegal funct3/funct7 -> TRAP. Otherwise -> EXEC.
- EXEC:
  - ALU/shift/compare controls driven per opcode.
  - SUB and compares use alu_inv_rs2=1, alu_cin=1.
  - AUIPC, JAL and BRANCH target use alu_mux_1_sel=1, alu_mux_2_sel=1.
  - LOAD or STORE -> MEM. Otherwise -> WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=(STORE).
  - mem_wmask: SB=4'b0001<<addr[1:0], SH=4'b0011<<{addr[1],1'b0}, SW=4'hF.
  - The controller does not check alignment.
  - Load controls are stable for the whole state. Wait for mem_resp, then -> WB.
- WB:
  - pc_en=1 for exactly one cycle.
  - pc_mux_sel=1 for JAL, JALR, and BRANCH with cmp_out true (BEQ/BNE/BLT/BGE/BLTU/BGEU polarity applied inside the controller). Otherwise 0.
  - rd_sel=one-hot(rd) if the instruction writes rd and rd!=0. Otherwise 32'h0.
  - BRANCH/STORE: rd_sel=0. Then -> FETCH.
- TRAP:
  - trap=1, mem_req=0, pc_en=0, rd_sel=0.
  - Stays in TRAP until rst.
- All control outputs are combinational from state and IR. mem_req never glitches within a state.
- Latency with zero-wait memory (mem_resp same cycle as request):
  - ALU/branch/jump: 4 cycles.
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- Reset mid-operation:
  - Any state goes to FETCH next cycle.
  - An in-flight mem_req drops in the reset cycle; a mem_resp arriving during reset is ignored.
  - No rd_sel or pc_en pulse other than the reset PC load.

Test Plan:
- Reset, then fetch `addi x5,x0,7` (32'h0070_0293), zero-wait -> states FETCH,DECODE,EXEC,WB; in WB rd_sel=32'h20, rd_mux_sel=0, alu_mux_2_sel=1, imm=7, pc_en=1, pc_mux_sel=0.
- `beq x1,x2,+8` with cmp_out=1 -> WB pc_mux_sel=1, rd_sel=0. Repeat with cmp_out=0 -> pc_mux_sel=0.
- `lbu x3,1(x4)` with mem_resp delayed 3 cycles in MEM -> mem_req held 4 cycles, addr_sel=1, lbu=1 throughout MEM, WB rd_sel=32'h8, rd_mux_sel=3.
- `sb` to address ending 2'b11 -> mem_we=1, mem_wmask=4'b1000, WB rd_sel=0.
- Fetch 32'hFFFF_FFFF -> DECODE then TRAP; trap=1, mem_req=0 held for 10 cycles; rst clears to FETCH.
- Assert rst during MEM wait -> next cycle FETCH, mem_req=0 during reset, no rd_sel pulse, pc_en=1 only in the reset cycle.
